// File: rtl/frame_downloader_pkg.sv
// ---------------------------------------------------------------------------
// frame_downloader_pkg
// Shared definitions for the PSRAM frame download path: burst geometry,
// 17-bit stream tags, the controller state encoding and the helper that
// sizes each burst against the remaining pixels of a row.
// Optional feature macro used by importers: FRAME_DOWNLOADER_READ_TIMEOUT_EN
// ---------------------------------------------------------------------------
package frame_downloader_pkg;

  // One PSRAM burst: 32 bytes = 16 RGB565 pixels = 8 x 32-bit words.
  localparam int MEMORY_BURST  = 32;
  localparam int PIX_PER_BURST = MEMORY_BURST / 2;
  localparam int BURST_CYCLES  = MEMORY_BURST / 4;

  // Stream tags; bit16 = 0 marks an ordinary pixel word.
  localparam logic [16:0] TAG_FRAME_START = 17'h10000;
  localparam logic [16:0] TAG_ROW_START   = 17'h10001;
  localparam logic [16:0] TAG_FRAME_END   = 17'h1FFFF;

  typedef enum logic [7:0] {
    IDLE,
    PUSH_FRAME_START,
    CHECK_ROW,
    PUSH_ROW_START,
    READ_REQUEST,
    READ_CMD,
    READ_DATA,
    WAIT_TRANSACTION_COMPLETE,
    DRAIN_CACHE,
    UPDATE_COUNTERS,
    PUSH_FRAME_END,
    DONE
  } t_state;

  // Pixels to emit from the next burst: min(PIX_PER_BURST, width - col).
  function automatic logic [10:0] burst_len(input logic [10:0] col,
                                            input logic [10:0] width);
    logic [10:0] remaining;
    remaining = width - col;
    return (remaining > 11'(PIX_PER_BURST)) ? 11'(PIX_PER_BURST) : remaining;
  endfunction

endpackage

// File: rtl/frame_downloader_burst_read_buffer.sv
// ---------------------------------------------------------------------------
// burst_read_buffer
// 8 x 32-bit register cache holding one PSRAM burst. Written one word at a
// time as read data arrives; read back one 16-bit pixel at a time, with the
// pixel in bits [15:0] of a word ordered before the pixel in bits [31:16].
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   we, widx, wdata  word write port
//   ridx             pixel index 0..15 (word = ridx[3:1], half = ridx[0])
//   rpix             selected pixel, combinational
// ---------------------------------------------------------------------------
module burst_read_buffer
  import frame_downloader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [2:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  ridx,
  output logic [15:0] rpix
);

  logic [31:0] word_q [BURST_CYCLES];
  logic [31:0] word_d [BURST_CYCLES];
  logic [31:0] sel_word;

  always_comb begin
    for (int i = 0; i < BURST_CYCLES; i++) begin
      word_d[i] = word_q[i];
    end
    if (we) begin
      word_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BURST_CYCLES; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BURST_CYCLES; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  assign sel_word = word_q[ridx[3:1]];
  assign rpix     = ridx[0] ? sel_word[31:16] : sel_word[15:0];

endmodule

// File: rtl/frame_downloader.sv
// ---------------------------------------------------------------------------
// frame_downloader
// Reads a stored frame back from PSRAM in 16-pixel bursts and emits it as
// the 17-bit tagged pixel stream (frame start, row start per row, pixels,
// frame end) towards the display-side FIFO.
// Optional feature: define FRAME_DOWNLOADER_READ_TIMEOUT_EN to zero-fill a
// burst that has not fully arrived by TCMD cycles after the read command and
// raise the sticky read_error flag. Without it, read_error is tied 0 and the
// controller waits for all 8 words.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, base_addr             launch one frame at base_addr (IDLE only)
//   read_rq, read_ack            arbiter request / grant
//   read_addr, mem_rd_en         burst address and one-cycle read command
//   read_data, read_data_valid   burst data words from memory
//   queue_full, queue_wr_en,
//   queue_data                   output FIFO interface
//   download_done                one-cycle pulse after the frame end tag
//   read_error                   sticky short-burst flag
// ---------------------------------------------------------------------------
module frame_downloader
  import frame_downloader_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int TCMD         = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [20:0] base_addr,
  output logic        read_rq,
  input  logic        read_ack,
  output logic [20:0] read_addr,
  output logic        mem_rd_en,
  input  logic [31:0] read_data,
  input  logic        read_data_valid,
  input  logic        queue_full,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        download_done,
  output logic        read_error
);

  localparam logic [10:0] WIDTH_L     = 11'(FRAME_WIDTH);
  localparam logic [10:0] HEIGHT_L    = 11'(FRAME_HEIGHT);
  localparam logic [7:0]  TCMD_L      = 8'(TCMD);
  localparam logic [3:0]  BURST_WORDS = 4'(BURST_CYCLES);

  t_state      state_q, state_d;
  logic [20:0] addr_q,  addr_d;
  logic [10:0] row_q,   row_d;
  logic [10:0] col_q,   col_d;
  logic [10:0] n_q,     n_d;
  logic [3:0]  w_q,     w_d;
  logic [3:0]  pix_q,   pix_d;
  logic [7:0]  cyc_q,   cyc_d;
  logic        err_q,   err_d;

  logic        push_pending;
  logic [16:0] push_data;
  logic        rq_c;
  logic        rd_en_c;
  logic        done_c;
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [15:0] buf_rpix;
  logic [10:0] col_sum;

  burst_read_buffer u_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .widx    (w_q[2:0]),
    .wdata   (buf_wdata),
    .ridx    (pix_q),
    .rpix    (buf_rpix)
  );

  assign col_sum = col_q + n_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_d        = row_q;
    col_d        = col_q;
    n_d          = n_q;
    w_d          = w_q;
    pix_d        = pix_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    push_pending = 1'b0;
    push_data    = '0;
    rq_c         = 1'b0;
    rd_en_c      = 1'b0;
    done_c       = 1'b0;
    buf_we       = 1'b0;
    buf_wdata    = read_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
          state_d = PUSH_FRAME_START;
        end
      end

      PUSH_FRAME_START: begin
        push_pending = 1'b1;
        push_data    = TAG_FRAME_START;
        if (!queue_full) begin
          state_d = CHECK_ROW;
        end
      end

      CHECK_ROW: begin
        state_d = (row_q == HEIGHT_L) ? PUSH_FRAME_END : PUSH_ROW_START;
      end

      PUSH_ROW_START: begin
        push_pending = 1'b1;
        push_data    = TAG_ROW_START;
        if (!queue_full) begin
          col_d   = '0;
          n_d     = burst_len(11'd0, WIDTH_L);
          state_d = READ_REQUEST;
        end
      end

      READ_REQUEST: begin
        rq_c = 1'b1;
        if (read_ack) begin
          state_d = READ_CMD;
        end
      end

      READ_CMD: begin
        // Cycle counter holds the number of cycles elapsed since mem_rd_en.
        rq_c    = 1'b1;
        rd_en_c = 1'b1;
        cyc_d   = 8'd1;
        w_d     = '0;
        pix_d   = '0;
        state_d = READ_DATA;
      end

      READ_DATA: begin
`ifdef FRAME_DOWNLOADER_READ_TIMEOUT_EN
        rq_c = (cyc_q < TCMD_L);
`else
        rq_c = 1'b1;
`endif
        if (cyc_q < TCMD_L) begin
          cyc_d = cyc_q + 8'd1;
        end
        if (w_q == BURST_WORDS) begin
          state_d = WAIT_TRANSACTION_COMPLETE;
`ifdef FRAME_DOWNLOADER_READ_TIMEOUT_EN
        end else if (cyc_q >= TCMD_L) begin
          // Burst came up short: fill the remaining words with zero, one per
          // cycle, and flag it. Late data is no longer accepted.
          buf_we    = 1'b1;
          buf_wdata = '0;
          w_d       = w_q + 4'd1;
          err_d     = 1'b1;
`endif
        end else if (read_data_valid) begin
          buf_we = 1'b1;
          w_d    = w_q + 4'd1;
        end
      end

      WAIT_TRANSACTION_COMPLETE: begin
        // Memory owns the bus until TCMD cycles after the command.
        rq_c = (cyc_q < TCMD_L);
        if (cyc_q < TCMD_L) begin
          cyc_d = cyc_q + 8'd1;
        end else begin
          state_d = DRAIN_CACHE;
        end
      end

      DRAIN_CACHE: begin
        push_pending = 1'b1;
        push_data    = {1'b0, buf_rpix};
        if (!queue_full) begin
          if (({7'd0, pix_q} + 11'd1) == n_q) begin
            state_d = UPDATE_COUNTERS;
          end else begin
            pix_d = pix_q + 4'd1;
          end
        end
      end

      UPDATE_COUNTERS: begin
        addr_d = addr_q + {10'd0, n_q};
        col_d  = col_sum;
        if (col_sum >= WIDTH_L) begin
          row_d   = row_q + 11'd1;
          state_d = CHECK_ROW;
        end else begin
          n_d     = burst_len(col_sum, WIDTH_L);
          state_d = READ_REQUEST;
        end
      end

      PUSH_FRAME_END: begin
        push_pending = 1'b1;
        push_data    = TAG_FRAME_END;
        if (!queue_full) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      n_q     <= '0;
      w_q     <= '0;
      pix_q   <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      n_q     <= n_d;
      w_q     <= w_d;
      pix_q   <= pix_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  assign queue_wr_en   = push_pending & ~queue_full;
  assign queue_data    = push_data;
  assign read_rq       = rq_c;
  assign mem_rd_en     = rd_en_c;
  assign read_addr     = addr_q;
  assign download_done = done_c;

`ifdef FRAME_DOWNLOADER_READ_TIMEOUT_EN
  assign read_error = err_q;
`else
  // err_q stays at its reset value in this build and is unused.
  assign read_error = 1'b0;
`endif

endmodule

// File: tb/tb_frame_downloader.sv
// Directed bench for frame_downloader with a 20x2 frame.
module tb_frame_downloader;

  localparam int W  = 20;
  localparam int H  = 2;
  localparam int TC = 19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [20:0] base_addr;
  logic        read_rq;
  logic        read_ack;
  logic [20:0] read_addr;
  logic        mem_rd_en;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        queue_full;
  logic        queue_wr_en;
  logic [16:0] queue_data;
  logic        download_done;
  logic        read_error;

  logic        arb_ack   = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_delay = 2;
  int          full_mode = 0;
  bit          short_once = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [16:0] got[$];
  logic [20:0] rd_addrs[$];

  assign read_ack = arb_ack | stray_ack;

  frame_downloader #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .TCMD        (TC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .read_rq        (read_rq),
    .read_ack       (read_ack),
    .read_addr      (read_addr),
    .mem_rd_en      (mem_rd_en),
    .read_data      (read_data),
    .read_data_valid(read_data_valid),
    .queue_full     (queue_full),
    .queue_wr_en    (queue_wr_en),
    .queue_data     (queue_data),
    .download_done  (download_done),
    .read_error     (read_error)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [20:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {11'd0, a[20:16]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [20:0] a, input int j);
    logic [20:0] lo;
    lo = a + 21'(2 * j);
    return {pix(lo + 21'd1), pix(lo)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbiter: grant ack_delay cycles after a request, then wait for release.
  initial begin
    forever begin
      @(negedge clk);
      if (read_rq === 1'b1) begin
        repeat (ack_delay) @(posedge clk);
        @(posedge clk); #1 arb_ack = 1'b1;
        @(posedge clk); #1 arb_ack = 1'b0;
        do @(negedge clk); while (read_rq === 1'b1);
      end
    end
  end

  // Memory: 8 words (plus one surplus word) starting the cycle after mem_rd_en.
  initial begin
    read_data_valid = 1'b0;
    read_data       = '0;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        logic [20:0] a;
        int nw;
        int extra;
        a = read_addr;
        rd_addrs.push_back(a);
        nw    = short_once ? 5 : 8;
        extra = short_once ? 0 : 1;
        short_once = 1'b0;
        for (int j = 0; j < nw + extra; j++) begin
          @(posedge clk); #1;
          read_data_valid = 1'b1;
          read_data       = (j < nw) ? mem_word(a, j) : 32'hDEADBEEF;
        end
        @(posedge clk); #1;
        read_data_valid = 1'b0;
        read_data       = '0;
      end
    end
  end

  // mem_rd_en width and read_rq hold time after the command.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        int len;
        len = 1;
        @(negedge clk);
        chk("rd_en_width", {31'd0, mem_rd_en}, 32'd0);
        while (read_rq === 1'b1 && len < 200) begin
          len++;
          @(negedge clk);
        end
        chk("rq_hold", len, TC);
      end
    end
  end

  // FIFO side: record pushes, never accept while full.
  initial begin
    forever begin
      @(negedge clk);
      if (queue_wr_en === 1'b1) begin
        chk("wr_while_full", {31'd0, queue_full}, 32'd0);
        got.push_back(queue_data);
      end
      if (download_done === 1'b1) done_cnt++;
    end
  end

  // queue_full pattern: 0 = never, 1 = full one cycle in three, 2 = always.
  initial begin
    int cnt;
    cnt = 0;
    queue_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      cnt++;
      case (full_mode)
        1:       queue_full = (cnt % 3 == 0);
        2:       queue_full = 1'b1;
        default: queue_full = 1'b0;
      endcase
    end
  end

  task automatic start_frame(input logic [20:0] base);
    got.delete();
    rd_addrs.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = '0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [20:0] base, input int z_lo, input int z_hi);
    logic [16:0] exp[$];
    logic [20:0] ea[4];
    exp.push_back(17'h10000);
    for (int r = 0; r < H; r++) begin
      exp.push_back(17'h10001);
      for (int c = 0; c < W; c++) begin
        if (r == 0 && c >= z_lo && c < z_hi) exp.push_back(17'h00000);
        else exp.push_back({1'b0, pix(base + 21'(r * W + c))});
      end
    end
    exp.push_back(17'h1FFFF);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_word%0d", tag, i), {15'd0, got[i]}, {15'd0, exp[i]});
    end
    ea[0] = base;
    ea[1] = base + 21'd16;
    ea[2] = base + 21'd20;
    ea[3] = base + 21'd36;
    chk({tag, "_nbursts"}, rd_addrs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {11'd0, (i < rd_addrs.size()) ? rd_addrs[i] : 21'h0}, {11'd0, ea[i]});
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_read_rq",   {31'd0, read_rq}, 32'd0);
    chk("rst_read_addr", {11'd0, read_addr}, 32'd0);
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_wr_en",     {31'd0, queue_wr_en}, 32'd0);
    chk("rst_qdata",     {15'd0, queue_data}, 32'd0);
    chk("rst_done",      {31'd0, download_done}, 32'd0);
    chk("rst_error",     {31'd0, read_error}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Grant with no request outstanding does nothing.
    repeat (2) @(posedge clk);
    #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_ack_rq", {31'd0, read_rq}, 32'd0);
    chk("stray_ack_cmds", rd_addrs.size(), 0);

    // Basic frame; a second start mid-frame must be ignored.
    start_frame(21'h000100);
    repeat (30) @(posedge clk);
    #1 base_addr = 21'h0ABCDE; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; base_addr = '0;
    wait_done("f1");
    check_frame("f1", 21'h000100, 0, 0);

    // Address wrap at the top of the 21-bit space.
    start_frame(21'h1FFFF8);
    wait_done("f2");
    check_frame("f2", 21'h1FFFF8, 0, 0);
    chk("f2_wrap_addr", {11'd0, (rd_addrs.size() > 1) ? rd_addrs[1] : 21'h0}, 32'h00000008);

    // Back-pressure one cycle in three plus a slow arbiter.
    full_mode = 1;
    ack_delay = 50;
    start_frame(21'h000400);
    wait_done("f3");
    check_frame("f3", 21'h000400, 0, 0);
    full_mode = 0;
    ack_delay = 2;

    // FIFO full indefinitely: nothing is pushed, no read is issued.
    full_mode = 2;
    start_frame(21'h000500);
    repeat (100) @(posedge clk);
    chk("stall_pushes", got.size(), 0);
    chk("stall_rq", {31'd0, read_rq}, 32'd0);
    full_mode = 0;
    wait_done("f4");
    check_frame("f4", 21'h000500, 0, 0);

    // Reset in the middle of draining a burst, then a clean frame.
    start_frame(21'h000600);
    n = 0;
    while (got.size() < 7 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("mid_drain_reached", {31'd0, got.size() >= 7}, 32'd1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_read_rq",   {31'd0, read_rq}, 32'd0);
    chk("mid_rst_read_addr", {11'd0, read_addr}, 32'd0);
    chk("mid_rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("mid_rst_wr_en",     {31'd0, queue_wr_en}, 32'd0);
    chk("mid_rst_qdata",     {15'd0, queue_data}, 32'd0);
    chk("mid_rst_done",      {31'd0, download_done}, 32'd0);
    chk("mid_rst_error",     {31'd0, read_error}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    start_frame(21'h000200);
    wait_done("f5");
    check_frame("f5", 21'h000200, 0, 0);

`ifdef FRAME_DOWNLOADER_READ_TIMEOUT_EN
    // First burst delivers only 5 words: pixels 10..15 of row 0 become 0.
    short_once = 1'b1;
    start_frame(21'h000300);
    wait_done("f6");
    check_frame("f6", 21'h000300, 10, 16);
    chk("timeout_error_set", {31'd0, read_error}, 32'd1);
    start_frame(21'h000340);
    repeat (3) @(negedge clk);
    chk("timeout_error_cleared", {31'd0, read_error}, 32'd0);
    wait_done("f7");
    check_frame("f7", 21'h000340, 0, 0);
`else
    chk("no_timeout_error", {31'd0, read_error}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
